cpu_bank_reg: RTL and testbench
===============================

# cpu_bank_reg

General-purpose register file of the CPU core: 32 × 32-bit architectural registers with two combinational read ports (A, B) and one synchronous write port. It sits in decode/writeback: decode drives the read addresses, writeback drives the write port. All ports except clock/reset are carried by the `CPU_bank_reg_if` interface bundle (module port `bank_reg_if`, slave modport).

## Interface
Parameters:
- `DATA_WIDTH`, 32, register width in bits.
- `NUM_REGS`, 32, number of registers.
- `ADDR_WIDTH`, $clog2(NUM_REGS) = 5, register index width.

Ports (one clock; reset is asynchronous and active-low):
- `clock`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-low reset; clears the whole bank.
- `bank_reg_if.write_enable`  input  1  write strobe.
- `bank_reg_if.write_reg`  input  ADDR_WIDTH  destination register index.
- `bank_reg_if.write_data`  input  DATA_WIDTH  value to write.
- `bank_reg_if.read_reg_a`  input  ADDR_WIDTH  read port A index.
- `bank_reg_if.read_reg_b`  input  ADDR_WIDTH  read port B index.
- `bank_reg_if.read_data_a`  output  DATA_WIDTH  contents of `read_reg_a`.
- `bank_reg_if.read_data_b`  output  DATA_WIDTH  contents of `read_reg_b`.

## Operation
- Storage: `NUM_REGS` registers of `DATA_WIDTH` bits.
- Register 0 is hardwired to zero. Writes to index 0 are discarded, and reads of index 0 return 0.
- Write: on a rising `clock` with `reset` high and `write_enable`=1, `regs[write_reg] <= write_data`.
- Write with `write_enable`=0: no state change.
- Read: `read_data_a` = `regs[read_reg_a]` and `read_data_b` = `regs[read_reg_b]`, purely combinational.
- Both read ports may address the same register; both then return the same value.
- Reset: while `reset`=0, every register is 0.
  - Clearing is immediate, without waiting for a clock edge.
  - Writes are ignored while reset is asserted, including a write whose clock edge coincides with reset.
- Reset asserted mid-operation discards all previously written values.
- No out-of-range index handling is needed, since all 2^ADDR_WIDTH indices exist.

## Timing
- Write latency: the value is stored at the rising edge where `write_enable` is sampled high.
  - It is visible on the read ports immediately after that edge, in the same cycle as the edge.
- Read latency: 0 cycles (combinational from the address and stored contents).
- Same-cycle read of a register being written (before the edge): behaviour depends on configuration (see below).
- Reset outputs: `read_data_a` = `read_data_b` = 0 for any address while reset is asserted.
  - They stay 0 after deassertion until a write occurs.
- Reset deassertion takes effect for writes at the first rising edge where `reset` is sampled high.

## Configuration
- `BANK_REG_BYPASS_EN` defined: write-to-read forwarding is enabled.
  - If `write_enable`=1, `write_reg`≠0 and `write_reg` equals a read index, that read port returns `write_data` combinationally, in the same cycle as the write.
  - Forwarding is suppressed while reset is asserted.
- Not defined: read ports return only stored contents. A same-cycle read returns the old value until the edge.

## Test plan
- Reset, then deassert; read A=2, B=1 → `read_data_a`=0x00000000, `read_data_b`=0x00000000.
- Write reg 2 = 0x2 (enable=1), next cycle read A=2, B=1 → A=0x00000002, B=0x00000000.
- Additionally write reg 1 = 0x14, then read A=2, B=1 → A=0x00000002, B=0x00000014.
- Assert reset with enable=0, deassert, read A=2, B=1 → A=0, B=0 (bank cleared asynchronously, before any clock edge).
- Write reg 0 = 0xDEADBEEF, read A=0, B=0 → both 0.
- Write reg 5 = 0xA5A5A5A5 while reading A=5, before the edge:
  - with `BANK_REG_BYPASS_EN` → A=0xA5A5A5A5;
  - without → A=0, becoming 0xA5A5A5A5 after the edge.

Source files
------------

// File: rtl/cpu_bank_reg_if.sv
// Signal bundle between decode/writeback and the general-purpose register file.
// The slave modport is the register file's view; master is the driver's view.
interface CPU_bank_reg_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] write_reg;
  logic [DATA_WIDTH-1:0] write_data;
  logic [ADDR_WIDTH-1:0] read_reg_a;
  logic [ADDR_WIDTH-1:0] read_reg_b;
  logic [DATA_WIDTH-1:0] read_data_a;
  logic [DATA_WIDTH-1:0] read_data_b;

  modport slave (
    input  write_enable, write_reg, write_data, read_reg_a, read_reg_b,
    output read_data_a, read_data_b
  );

  modport master (
    output write_enable, write_reg, write_data, read_reg_a, read_reg_b,
    input  read_data_a, read_data_b
  );
endinterface

// File: rtl/cpu_bank_reg.sv
// 32 x 32-bit register file: two combinational read ports, one synchronous write port.
// Define BANK_REG_BYPASS_EN to forward same-cycle write data onto matching read ports.
module cpu_bank_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input logic            clock,
  input logic            reset,
  CPU_bank_reg_if.slave  bank_reg_if
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  write_hit;

  // Register 0 is never written, so it holds its reset value of zero.
  assign write_hit = bank_reg_if.write_enable && (bank_reg_if.write_reg != '0);

  // NOTE: every entry is a flop on the async reset, so the whole bank clears
  // the instant reset asserts; this is why the storage cannot be a RAM macro.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_hit) begin
      // NOTE: non-blocking so reads in the same time step see the pre-edge value.
      regs[bank_reg_if.write_reg] <= bank_reg_if.write_data;
    end
  end

  // NOTE: outputs get a default first so no path through the block infers a latch.
  always_comb begin
    bank_reg_if.read_data_a = (bank_reg_if.read_reg_a == '0) ? '0 : regs[bank_reg_if.read_reg_a];
    bank_reg_if.read_data_b = (bank_reg_if.read_reg_b == '0) ? '0 : regs[bank_reg_if.read_reg_b];
`ifdef BANK_REG_BYPASS_EN
    if (reset && write_hit && (bank_reg_if.write_reg == bank_reg_if.read_reg_a)) begin
      bank_reg_if.read_data_a = bank_reg_if.write_data;
    end
    if (reset && write_hit && (bank_reg_if.write_reg == bank_reg_if.read_reg_b)) begin
      bank_reg_if.read_data_b = bank_reg_if.write_data;
    end
`else
    // Without forwarding a same-cycle read sees the old contents until the edge.
`endif
  end

endmodule

// File: tb/tb_cpu_bank_reg.sv
// Self-checking bench for cpu_bank_reg against an array-based register model.
// Covers reset, directed writes, register 0, same-cycle read, async reset and random traffic.
module tb_cpu_bank_reg;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [31:0] model [32];

  CPU_bank_reg_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bif ();

  cpu_bank_reg #(.DATA_WIDTH(32), .NUM_REGS(32), .ADDR_WIDTH(5)) dut (
    .clock       (clock),
    .reset       (reset),
    .bank_reg_if (bif.slave)
  );

  always #5 clock = ~clock;

`ifdef BANK_REG_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Architectural view of a read: forwarding applies only with reset released.
  function automatic logic [31:0] expect_read(input logic [4:0] addr);
    if (addr == 5'd0) return 32'd0;
    if (BYPASS && reset && bif.write_enable && bif.write_reg == addr) return bif.write_data;
    if (!reset) return 32'd0;
    return model[addr];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb);
    bif.write_enable = we;
    bif.write_reg    = wa;
    bif.write_data   = wd;
    bif.read_reg_a   = ra;
    bif.read_reg_b   = rb;
  endtask

  // Clock edge plus model update; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clock);
    if (reset && bif.write_enable && bif.write_reg != 5'd0) model[bif.write_reg] = bif.write_data;
    #1;
  endtask

  task automatic test_reset();
    clear_model();
    drive(1'b1, 5'd3, 32'h1234_5678, 5'd3, 5'd2);
    tick();
    n_cmp++;
    if (bif.read_data_a !== 32'd0) begin
      n_err++;
      $display("FAIL reset_write_ignored: got %h want %h", bif.read_data_a, 32'd0);
    end
    @(negedge clock);
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 5'd2, 5'd1);
    #1;
    n_cmp++;
    if (bif.read_data_a !== 32'd0) begin
      n_err++;
      $display("FAIL reset_read_a: got %h want %h", bif.read_data_a, 32'd0);
    end
    n_cmp++;
    if (bif.read_data_b !== 32'd0) begin
      n_err++;
      $display("FAIL reset_read_b: got %h want %h", bif.read_data_b, 32'd0);
    end
  endtask

  task automatic test_directed();
    @(negedge clock);
    drive(1'b1, 5'd2, 32'h2, 5'd2, 5'd1);
    tick();
    @(negedge clock);
    drive(1'b0, 5'd0, 32'd0, 5'd2, 5'd1);
    #1;
    n_cmp++;
    if (bif.read_data_a !== 32'h2) begin
      n_err++;
      $display("FAIL dir_w2_a: got %h want %h", bif.read_data_a, 32'h2);
    end
    n_cmp++;
    if (bif.read_data_b !== 32'h0) begin
      n_err++;
      $display("FAIL dir_w2_b: got %h want %h", bif.read_data_b, 32'h0);
    end
    drive(1'b1, 5'd1, 32'h14, 5'd2, 5'd1);
    tick();
    @(negedge clock);
    drive(1'b0, 5'd0, 32'd0, 5'd2, 5'd1);
    #1;
    n_cmp++;
    if (bif.read_data_a !== 32'h2) begin
      n_err++;
      $display("FAIL dir_w1_a: got %h want %h", bif.read_data_a, 32'h2);
    end
    n_cmp++;
    if (bif.read_data_b !== 32'h14) begin
      n_err++;
      $display("FAIL dir_w1_b: got %h want %h", bif.read_data_b, 32'h14);
    end
    drive(1'b0, 5'd0, 32'd0, 5'd1, 5'd1);
    #1;
    n_cmp++;
    if (bif.read_data_a !== 32'h14 || bif.read_data_b !== 32'h14) begin
      n_err++;
      $display("FAIL same_addr: got a=%h b=%h want %h", bif.read_data_a, bif.read_data_b, 32'h14);
    end
  endtask

  task automatic test_async_reset();
    // Clear between clock edges and check before any edge can occur.
    @(negedge clock);
    drive(1'b0, 5'd0, 32'd0, 5'd2, 5'd1);
    #1;
    reset = 1'b0;
    #1;
    clear_model();
    n_cmp++;
    if (bif.read_data_a !== 32'd0 || bif.read_data_b !== 32'd0) begin
      n_err++;
      $display("FAIL async_clear: got a=%h b=%h want 0", bif.read_data_a, bif.read_data_b);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bif.read_data_a !== 32'd0 || bif.read_data_b !== 32'd0) begin
      n_err++;
      $display("FAIL after_deassert: got a=%h b=%h want 0", bif.read_data_a, bif.read_data_b);
    end
    // Reset asserted exactly at a write edge must leave the register clear.
    @(negedge clock);
    drive(1'b1, 5'd7, 32'hCAFE_F00D, 5'd7, 5'd7);
    @(posedge clock);
    reset = 1'b0;
    #1;
    clear_model();
    @(negedge clock);
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 5'd7, 5'd7);
    #1;
    n_cmp++;
    if (bif.read_data_a !== 32'd0) begin
      n_err++;
      $display("FAIL coincident_write: got %h want %h", bif.read_data_a, 32'd0);
    end
  endtask

  task automatic test_reg0();
    @(negedge clock);
    drive(1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0);
    #1;
    n_cmp++;
    if (bif.read_data_a !== 32'd0) begin
      n_err++;
      $display("FAIL reg0_pre: got %h want %h", bif.read_data_a, 32'd0);
    end
    tick();
    n_cmp++;
    if (bif.read_data_a !== 32'd0 || bif.read_data_b !== 32'd0) begin
      n_err++;
      $display("FAIL reg0_post: got a=%h b=%h want 0", bif.read_data_a, bif.read_data_b);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] want_pre;
    want_pre = BYPASS ? 32'hA5A5_A5A5 : 32'd0;
    @(negedge clock);
    drive(1'b1, 5'd5, 32'hA5A5_A5A5, 5'd5, 5'd4);
    #1;
    n_cmp++;
    if (bif.read_data_a !== want_pre) begin
      n_err++;
      $display("FAIL same_cycle_pre: got %h want %h", bif.read_data_a, want_pre);
    end
    tick();
    n_cmp++;
    if (bif.read_data_a !== 32'hA5A5_A5A5) begin
      n_err++;
      $display("FAIL same_cycle_post: got %h want %h", bif.read_data_a, 32'hA5A5_A5A5);
    end
    @(negedge clock);
    drive(1'b0, 5'd5, 32'h0, 5'd5, 5'd4);
    #1;
    n_cmp++;
    if (bif.read_data_a !== 32'hA5A5_A5A5) begin
      n_err++;
      $display("FAIL write_disabled: got %h want %h", bif.read_data_a, 32'hA5A5_A5A5);
    end
  endtask

  task automatic test_random();
    logic        we;
    logic [4:0]  wa, ra, rb;
    logic [31:0] wd, ea, eb;
    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      we = ($urandom_range(0, 3) != 0);
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
      drive(we, wa, wd, ra, rb);
      #1;
      ea = expect_read(ra);
      eb = expect_read(rb);
      n_cmp++;
      if (bif.read_data_a !== ea || bif.read_data_b !== eb) begin
        n_err++;
        $display("FAIL rand_pre[%0d]: got a=%h b=%h want a=%h b=%h", n, bif.read_data_a, bif.read_data_b, ea, eb);
      end
      tick();
      ea = expect_read(ra);
      eb = expect_read(rb);
      n_cmp++;
      if (bif.read_data_a !== ea || bif.read_data_b !== eb) begin
        n_err++;
        $display("FAIL rand_post[%0d]: got a=%h b=%h want a=%h b=%h", n, bif.read_data_a, bif.read_data_b, ea, eb);
      end
    end
  endtask

  initial begin
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    test_reset();
    test_directed();
    test_async_reset();
    test_reg0();
    test_same_cycle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
